bus_control_fsm: RTL

- Multi-cycle control unit that drives the select and enable signals of the 9-bit processor datapath bus.
- It decodes the instruction register and sequences time steps T0..T3.
- Per cycle it asserts at most one bus source: Rout one-hot, Gout or DINout. It also asserts the matching register, A, G and IR load enables, plus Done at instruction end.

---
 rtl/bus_control_fsm.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bus_control_fsm.sv
// Control sequencer for the 9-bit processor bus: decodes IR and walks T0..T3, driving bus source and load enables.
// Latency: mv/mvi/mvnz/reserved take 2 cycles including T0; add/sub take 4. Outputs are combinational from state/IR/G_nz.
// Backpressure: none; Run is sampled only in T0, and holding it high issues instructions back-to-back.
module bus_control_fsm #(
    parameter bit MVNZ_EN = 1'b1
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [8:0] IR,
    input  logic       G_nz,
    output logic       IRin,
    output logic [7:0] Rout,
    output logic       Gout,
    output logic       DINout,
    output logic [7:0] Rin,
    output logic       Ain,
    output logic       Gin,
    output logic       AddSub,
    output logic       Done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_MVNZ = 3'b100,
        OP_RSV5 = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } opcode_t;

    state_t     state_q;
    state_t     state_d;
    opcode_t    opcode;
    logic [7:0] x_oh;
    logic [7:0] y_oh;

    assign opcode = opcode_t'(IR[8:6]);
    assign x_oh   = 8'd1 << IR[5:3];
    assign y_oh   = 8'd1 << IR[2:0];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= T0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        IRin    = 1'b0;
        Rout    = 8'h00;
        Gout    = 1'b0;
        DINout  = 1'b0;
        Rin     = 8'h00;
        Ain     = 1'b0;
        Gin     = 1'b0;
        AddSub  = 1'b0;
        Done    = 1'b0;

        // Outputs are forced quiet while reset is held, even if Run is already high.
        if (Resetn) begin
            case (state_q)
                T0: begin
                    if (Run) begin
                        IRin    = 1'b1;
                        state_d = T1;
                    end
                end
                T1: begin
                    state_d = T0;
                    case (opcode)
                        OP_MV: begin
                            Rout = y_oh;
                            Rin  = x_oh;
                            Done = 1'b1;
                        end
                        OP_MVI: begin
                            DINout = 1'b1;
                            Rin    = x_oh;
                            Done   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            Rout    = x_oh;
                            Ain     = 1'b1;
                            state_d = T2;
                        end
                        OP_MVNZ: begin
                            // Conditional move completes in one step whether or not it copies.
                            if (MVNZ_EN && G_nz) begin
                                Rout = y_oh;
                                Rin  = x_oh;
                            end
                            Done = 1'b1;
                        end
                        OP_RSV5, OP_RSV6, OP_RSV7: begin
                            Done = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    Rout    = y_oh;
                    Gin     = 1'b1;
                    AddSub  = IR[6];
                    state_d = T3;
                end
                T3: begin
                    Gout    = 1'b1;
                    Rin     = x_oh;
                    Done    = 1'b1;
                    state_d = T0;
                end
            endcase
        end
    end

endmodule
